// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
//
// Direct-mapped, write-through, no-write-allocate data cache between the CPU
// memory stage and data memory. One 32-bit word per line. Loads that hit are
// answered combinationally. An aligned load miss costs two stall cycles:
//   - the miss cycle, which latches the word address
//   - the refill cycle, which drives memory and captures mem_rd into the line
// After that the held request hits. Stores always go straight through to
// memory with no stall. A store that hits also patches the resident line.
// Misaligned word loads bypass the line store entirely.
//
// Optional feature macro: DCACHE_STATS_EN
//   defined     -> hit_count / miss_count are live 32-bit wrapping counters
//   not defined -> both counters are tied to zero
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   addr          CPU byte address
//   wdata         CPU store data
//   re, we        load / store request (store wins when both are high)
//   adtp          0 = word access, 1 = byte access (loads zero-extended)
//   rdata         load data, valid when re=1 and stall=0
//   stall         CPU must hold its request while high
//   mem_a         data memory address
//   mem_wd        data memory write data
//   mem_we        data memory write enable
//   mem_adtp      data memory access type
//   mem_rd        data memory read data (combinational from mem_a)
//   hit_count     load-hit counter
//   miss_count    load-miss counter
// -----------------------------------------------------------------------------
module data_cache #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS_LOG2     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic                     we,
    input  logic                     adtp,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     stall,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    output logic                     mem_we,
    output logic                     mem_adtp,
    input  logic [DATA_WIDTH-1:0]    mem_rd,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
);

    localparam int SETS    = 1 << SETS_LOG2;
    localparam int TAG_W   = ADDRESS_WIDTH - SETS_LOG2 - 2;
    localparam int LANES   = DATA_WIDTH / 8;
    localparam int WADDR_W = ADDRESS_WIDTH - 2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Address split of the live CPU request
    logic [1:0]           offset;
    logic [SETS_LOG2-1:0] index;
    logic [SETS_LOG2-1:0] index_plus1;
    logic [TAG_W-1:0]     tag;

    assign offset      = addr[1:0];
    assign index       = addr[SETS_LOG2+1:2];
    assign tag         = addr[ADDRESS_WIDTH-1:SETS_LOG2+2];
    // Set holding the word after addr; a misaligned word store spills into it
    assign index_plus1 = index + SETS_LOG2'(1);

    // Line store
    logic [SETS-1:0]      valid_reg;
    logic [TAG_W-1:0]     tag_mem [SETS];
    logic [DATA_WIDTH-1:0] line_word;

    // Word address ({tag,index}) captured on the miss cycle. The refill uses
    // this rather than the live request.
    logic [WADDR_W-1:0]   fill_addr_reg;
    logic [SETS_LOG2-1:0] fill_index;
    logic [TAG_W-1:0]     fill_tag;

    assign fill_index = fill_addr_reg[SETS_LOG2-1:0];
    assign fill_tag   = fill_addr_reg[WADDR_W-1:SETS_LOG2];

    logic       hit;
    logic       aligned;
    logic [7:0] byte_sel;

    assign hit      = valid_reg[index] && (tag_mem[index] == tag);
    assign aligned  = adtp || (offset == 2'b00);
    assign byte_sel = line_word[{offset, 3'b000} +: 8];

    // Line write controls produced by the FSM
    logic [LANES-1:0]      lane_we;
    logic [DATA_WIDTH-1:0] line_wdata;
    logic [SETS_LOG2-1:0]  line_index;
    logic                  tag_we;
    logic                  fill_latch;
    logic                  inval_en;

    // -------------------------------------------------------------------------
    // Next-state and outputs. While rst is high nothing is written and the
    // CPU sees an idle, non-stalling cache even if the FSM is still in REFILL.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        rdata      = '0;
        mem_a      = addr;
        mem_wd     = wdata;
        mem_we     = 1'b0;
        mem_adtp   = adtp;
        lane_we    = '0;
        line_wdata = wdata;
        line_index = index;
        tag_we     = 1'b0;
        fill_latch = 1'b0;
        inval_en   = 1'b0;

        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (we) begin
                        mem_we = 1'b1;
                        if (aligned && hit) begin
                            if (adtp) begin
                                lane_we[offset] = 1'b1;
                                line_wdata      = {LANES{wdata[7:0]}};
                            end else begin
                                lane_we = '1;
                            end
                        end else if (!aligned) begin
                            inval_en = 1'b1;
                        end
                    end else if (re) begin
                        if (!aligned) begin
                            mem_adtp = 1'b0;
                            rdata    = mem_rd;
                        end else if (hit) begin
                            rdata = adtp ? {{(DATA_WIDTH-8){1'b0}}, byte_sel} : line_word;
                        end else begin
                            stall      = 1'b1;
                            fill_latch = 1'b1;
                            state_next = REFILL;
                        end
                    end
                end
                REFILL: begin
                    stall      = 1'b1;
                    mem_a      = {fill_addr_reg, 2'b00};
                    mem_adtp   = 1'b0;
                    lane_we    = '1;
                    line_wdata = mem_rd;
                    line_index = fill_index;
                    tag_we     = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_latch) begin
            fill_addr_reg <= addr[ADDRESS_WIDTH-1:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (tag_we) begin
            valid_reg[fill_index] <= 1'b1;
        end else if (inval_en) begin
            valid_reg[index]       <= 1'b0;
            valid_reg[index_plus1] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[fill_index] <= fill_tag;
        end
    end

    // One byte-wide array per lane so a byte store touches only its own lane
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [SETS];

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    lane_mem[line_index] <= line_wdata[gi*8 +: 8];
                end
            end

            assign line_word[gi*8 +: 8] = lane_mem[index];
        end
    endgenerate

`ifdef DCACHE_STATS_EN
    logic        hit_evt;
    logic        miss_evt;
    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;

    // Only IDLE load cycles count. The cycle after a refill is a real hit.
    assign hit_evt  = !rst && (state_reg == IDLE) && re && !we && aligned && hit;
    assign miss_evt = !rst && (state_reg == IDLE) && re && !we && aligned && !hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (hit_evt) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (miss_evt) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// -----------------------------------------------------------------------------
// tb_data_cache
//
// Bench for data_cache. It contains:
//   - a 4 KiB byte-addressed data memory, driven only by the DUT's mem_* pins
//   - a reference model, described below
//   - a per-cycle compare process that checks the DUT outputs against the model
//   - directed scenarios with literal expectations, then randomized traffic
//
// The reference model is kept in terms of what the CPU should observe:
//   - its own copy of memory contents, updated from CPU stores
//   - which word tag is resident in each set
//   - whether a refill is pending
// Load data is always predicted from the model memory, because a
// write-through cache must agree with memory.
// -----------------------------------------------------------------------------
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        re_i;
    logic        we_i;
    logic        adtp_i;
    logic [31:0] rdata;
    logic        stall;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic        mem_adtp;
    logic [31:0] mem_rd;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    data_cache dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr_i),
        .wdata      (wdata_i),
        .re         (re_i),
        .we         (we_i),
        .adtp       (adtp_i),
        .rdata      (rdata),
        .stall      (stall),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_adtp   (mem_adtp),
        .mem_rd     (mem_rd),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Initial memory image. Test words live at 0x000 and 0x020.
    function automatic logic [7:0] init_byte(input int i);
        logic [7:0] v;
        v = 8'(i * 29 + 7) ^ 8'hA5;
        case (i)
            0:  v = 8'hEF;
            1:  v = 8'hBE;
            2:  v = 8'hAD;
            3:  v = 8'hDE;
            32: v = 8'h78;
            33: v = 8'h56;
            34: v = 8'h34;
            35: v = 8'h12;
            default: ;
        endcase
        return v;
    endfunction

    // ---------------- data memory (environment) ----------------
    logic [7:0]  env_mem [4096];
    logic [11:0] ma;

    assign ma     = mem_a[11:0];
    assign mem_rd = {env_mem[ma + 12'd3], env_mem[ma + 12'd2], env_mem[ma + 12'd1], env_mem[ma]};

    initial begin
        for (int i = 0; i < 4096; i++) env_mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (mem_we) begin
                if (mem_adtp) begin
                    env_mem[ma] = mem_wd[7:0];
                end else begin
                    for (int b = 0; b < 4; b++) env_mem[ma + 12'(b)] = mem_wd[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [4096];
    logic [7:0]  m_valid;
    logic [26:0] m_tag [8];
    logic [29:0] m_fill;
    bit          m_refill;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    function automatic logic [31:0] ref_word(input logic [11:0] a);
        return {ref_mem[a + 12'd3], ref_mem[a + 12'd2], ref_mem[a + 12'd1], ref_mem[a]};
    endfunction

    // Per-cycle compare. Runs on the falling edge, so inputs and outputs are
    // settled. Model state is advanced to what the next rising edge produces.
    initial begin
        logic [11:0] a;
        logic [2:0]  idx;
        logic [31:0] exp_h;
        logic [31:0] exp_m;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
        m_valid  = '0;
        m_refill = 0;
        m_hits   = '0;
        m_misses = '0;
        m_fill   = '0;
        for (int i = 0; i < 8; i++) m_tag[i] = '0;
        forever begin
            @(negedge clk);
            a   = addr_i[11:0];
            idx = addr_i[4:2];
`ifdef DCACHE_STATS_EN
            exp_h = m_hits;
            exp_m = m_misses;
`else
            exp_h = '0;
            exp_m = '0;
`endif
            chk("hit_count", hit_count, exp_h);
            chk("miss_count", miss_count, exp_m);
            if (rst) begin
                chk("rst_stall", {31'b0, stall}, 32'd0);
                chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
                if (!re_i) chk("rst_rdata", rdata, 32'd0);
                m_valid  = '0;
                m_refill = 0;
                m_hits   = '0;
                m_misses = '0;
            end else if (m_refill) begin
                chk("refill_stall", {31'b0, stall}, 32'd1);
                chk("refill_mem_we", {31'b0, mem_we}, 32'd0);
                chk("refill_mem_a", mem_a, {m_fill, 2'b00});
                chk("refill_mem_adtp", {31'b0, mem_adtp}, 32'd0);
                m_valid[m_fill[2:0]] = 1'b1;
                m_tag[m_fill[2:0]]   = m_fill[29:3];
                m_refill             = 0;
            end else if (we_i) begin
                chk("store_stall", {31'b0, stall}, 32'd0);
                chk("store_mem_we", {31'b0, mem_we}, 32'd1);
                chk("store_mem_a", mem_a, addr_i);
                chk("store_mem_wd", mem_wd, wdata_i);
                chk("store_mem_adtp", {31'b0, mem_adtp}, {31'b0, adtp_i});
                if (adtp_i) begin
                    ref_mem[a] = wdata_i[7:0];
                end else begin
                    for (int b = 0; b < 4; b++) ref_mem[a + 12'(b)] = wdata_i[b*8 +: 8];
                    if (addr_i[1:0] != 2'b00) begin
                        m_valid[idx]        = 1'b0;
                        m_valid[idx + 3'd1] = 1'b0;
                    end
                end
            end else if (re_i) begin
                if (!adtp_i && addr_i[1:0] != 2'b00) begin
                    chk("ua_stall", {31'b0, stall}, 32'd0);
                    chk("ua_mem_we", {31'b0, mem_we}, 32'd0);
                    chk("ua_mem_a", mem_a, addr_i);
                    chk("ua_mem_adtp", {31'b0, mem_adtp}, 32'd0);
                    chk("ua_rdata", rdata, ref_word(a));
                end else if (m_valid[idx] && m_tag[idx] == addr_i[31:5]) begin
                    chk("hit_stall", {31'b0, stall}, 32'd0);
                    chk("hit_mem_we", {31'b0, mem_we}, 32'd0);
                    chk("hit_rdata", rdata, adtp_i ? {24'b0, ref_mem[a]} : ref_word(a));
                    m_hits = m_hits + 32'd1;
                end else begin
                    chk("miss_stall", {31'b0, stall}, 32'd1);
                    chk("miss_mem_we", {31'b0, mem_we}, 32'd0);
                    m_refill = 1;
                    m_fill   = addr_i[31:2];
                    m_misses = m_misses + 32'd1;
                end
            end else begin
                chk("idle_stall", {31'b0, stall}, 32'd0);
                chk("idle_mem_we", {31'b0, mem_we}, 32'd0);
                chk("idle_mem_a", mem_a, addr_i);
                chk("idle_mem_adtp", {31'b0, mem_adtp}, {31'b0, adtp_i});
                chk("idle_rdata", rdata, 32'd0);
            end
        end
    end

    // One CPU transaction: hold the request until a non-stalled cycle, then
    // release it at the next rising edge.
    task automatic op(input logic r, input logic w, input logic t,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int stalls);
        bit done;
        re_i    = r;
        we_i    = w;
        adtp_i  = t;
        addr_i  = a;
        wdata_i = d;
        stalls  = 0;
        rd      = '0;
        done    = 0;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            if (!stall) begin
                rd   = rdata;
                done = 1;
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL op_timeout actual=stall_stuck required=release addr=%h", a);
        end
        @(posedge clk);
        #1;
        $display("op re=%0b we=%0b byte=%0b addr=%h wdata=%h rdata=%h stalls=%0d",
                 r, w, t, a, d, rd, stalls);
    endtask

    initial begin
        logic [31:0] rd;
        int          st;
        int          k;
        rst     = 1'b1;
        re_i    = 1'b0;
        we_i    = 1'b0;
        adtp_i  = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_hit_count", hit_count, 32'd0);
        chk("reset_miss_count", miss_count, 32'd0);

        // Cold word load: two stall cycles, then memory data
        op(1, 0, 0, 32'h0001_0000, 0, rd, st);
        chk("cold_load_stalls", 32'(st), 32'd2);
        chk("cold_load_rdata", rd, 32'hDEAD_BEEF);
`ifdef DCACHE_STATS_EN
        chk("cold_load_miss_count", miss_count, 32'd1);
`endif
        // Byte hit on lane 2
        op(1, 0, 1, 32'h0001_0002, 0, rd, st);
        chk("byte_hit_stalls", 32'(st), 32'd0);
        chk("byte_hit_rdata", rd, 32'h0000_00AD);
`ifdef DCACHE_STATS_EN
        chk("byte_hit_hit_count", hit_count, 32'd2);
`endif
        op(1, 0, 0, 32'h0001_0000, 0, rd, st);
        chk("repeat_hit_stalls", 32'(st), 32'd0);
        chk("repeat_hit_rdata", rd, 32'hDEAD_BEEF);

        // Byte store into a resident line patches lane 1 only
        op(0, 1, 1, 32'h0001_0001, 32'h0000_005A, rd, st);
        chk("byte_store_stalls", 32'(st), 32'd0);
        op(1, 0, 0, 32'h0001_0000, 0, rd, st);
        chk("patched_stalls", 32'(st), 32'd0);
        chk("patched_rdata", rd, 32'hDEAD_5AEF);

        // Index conflict evicts, then the original word misses again
        op(1, 0, 0, 32'h0001_0020, 0, rd, st);
        chk("conflict_stalls", 32'(st), 32'd2);
        chk("conflict_rdata", rd, 32'h1234_5678);
        op(1, 0, 0, 32'h0001_0000, 0, rd, st);
        chk("evicted_stalls", 32'(st), 32'd2);
        chk("evicted_rdata", rd, 32'hDEAD_5AEF);

        // No-write-allocate store, then the load must miss
        op(0, 1, 0, 32'h0001_0040, 32'h1122_3344, rd, st);
        chk("na_store_stalls", 32'(st), 32'd0);
        op(1, 0, 0, 32'h0001_0040, 0, rd, st);
        chk("na_load_stalls", 32'(st), 32'd2);
        chk("na_load_rdata", rd, 32'h1122_3344);

        // Reset asserted in the refill cycle
        re_i   = 1'b1;
        we_i   = 1'b0;
        adtp_i = 1'b0;
        addr_i = 32'h0001_0060;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_refill_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("op reset during refill addr=%h", addr_i);
        op(1, 0, 0, 32'h0001_0060, 0, rd, st);
        chk("after_rst_stalls", 32'(st), 32'd2);
        chk("after_rst_rdata", rd, {init_byte(16'h63), init_byte(16'h62), init_byte(16'h61), init_byte(16'h60)});

        // Randomized traffic over 128 bytes: 8 sets x 4 tags
        for (int n = 0; n < 400; n++) begin
            k = int'($urandom_range(0, 99));
            if (k < 2) begin
                rst    = 1'b1;
                re_i   = 1'b0;
                we_i   = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                $display("op reset");
            end else begin
                op((k < 40) || (k >= 70 && k < 80),
                   (k >= 40 && k < 80),
                   1'($urandom_range(0, 1)),
                   32'h0001_0000 | 32'($urandom_range(0, 127)),
                   $urandom, rd, st);
            end
        end

        re_i = 1'b0;
        we_i = 1'b0;
        @(negedge clk);
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
